alu_mux_addsub: RTL and testbench

ALU_MUX_ADDSUB -- requirements
Module: alu_mux_addsub

---
 rtl/alu_mux_addsub_pkg.sv | 16 +
 rtl/rc_add_sub_n.sv | 29 ++
 rtl/alu_mux_addsub.sv | 74 +++++++
 tb/tb_alu_mux_addsub.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/alu_mux_addsub_pkg.sv
// Shared datapath width and operation codes for the alu_mux_addsub block.
package alu_mux_addsub_pkg;

    localparam int WIDTH = 32;

    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_MUL = 6'h03;
    localparam logic [5:0] OP_SHR = 6'h04;
    localparam logic [5:0] OP_SHL = 6'h05;
    localparam logic [5:0] OP_AND = 6'h06;
    localparam logic [5:0] OP_OR  = 6'h07;
    localparam logic [5:0] OP_NOR = 6'h08;
    localparam logic [5:0] OP_SLT = 6'h09;

endpackage

// File: rtl/rc_add_sub_n.sv
// WIDTH-bit ripple-carry adder/subtractor; SnA=1 subtracts by inverting B
// and feeding a carry-in of 1, so CO=1 means "no borrow".
module rc_add_sub_n #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SnA,
    output logic [WIDTH-1:0] Y,
    output logic             CO
);

    logic [WIDTH-1:0] b_eff;
    logic             carry;

    assign b_eff = B ^ {WIDTH{SnA}};

    // Carry kept in a loop variable so the chain is one combinational walk.
    always_comb begin
        Y     = '0;
        carry = SnA;
        for (int i = 0; i < WIDTH; i++) begin
            Y[i]  = A[i] ^ b_eff[i] ^ carry;
            carry = (A[i] & b_eff[i]) | (A[i] & carry) | (b_eff[i] & carry);
        end
        CO = carry;
    end

endmodule

// File: rtl/alu_mux_addsub.sv
// Registered ALU with IMM/B operand-2 mux and ripple adder/subtractor.
// Define ALU_MUL_EN to build the multiplier for opcode 0x03.
module alu_mux_addsub
    import alu_mux_addsub_pkg::*;
#(
    parameter int WIDTH = alu_mux_addsub_pkg::WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] IMM,
    input  logic             OP2_SEL,
    input  logic [5:0]       OPRN,
    output logic [WIDTH-1:0] Y,
    output logic             ZERO,
    output logic             CO
);

    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] sum;
    logic             sum_co;
    logic [WIDTH-1:0] y_nxt;
    logic             co_nxt;

    assign b2 = OP2_SEL ? B : IMM;

    rc_add_sub_n #(.WIDTH(WIDTH)) u_add_sub (
        .A   (A),
        .B   (b2),
        .SnA (OPRN == OP_SUB),
        .Y   (sum),
        .CO  (sum_co)
    );

    always_comb begin
        y_nxt  = '0;
        co_nxt = 1'b0;
        case (OPRN)
            OP_ADD, OP_SUB: begin
                y_nxt  = sum;
                co_nxt = sum_co;
            end
`ifdef ALU_MUL_EN
            OP_MUL: y_nxt = A * b2;
`endif
            // Shift amounts >= WIDTH yield zero by language semantics.
            OP_SHR: y_nxt = A >> b2;
            OP_SHL: y_nxt = A << b2;
            OP_AND: y_nxt = A & b2;
            OP_OR:  y_nxt = A | b2;
            OP_NOR: y_nxt = ~(A | b2);
            OP_SLT: y_nxt = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(b2))};
            default: begin
                y_nxt  = '0;
                co_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Y    <= '0;
            ZERO <= 1'b1;
            CO   <= 1'b0;
        end else if (EN) begin
            Y    <= y_nxt;
            ZERO <= ~|y_nxt;
            CO   <= co_nxt;
        end
    end

endmodule

// File: tb/tb_alu_mux_addsub.sv
// Self-checking bench for alu_mux_addsub: directed cases then random
// stimulus against an arithmetic reference model.
module tb_alu_mux_addsub;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] IMM = '0;
    logic        OP2_SEL = 1'b0;
    logic [5:0]  OPRN = '0;
    logic [31:0] Y;
    logic        ZERO;
    logic        CO;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_y = '0;
    logic        m_co = 1'b0;

    alu_mux_addsub dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .A       (A),
        .B       (B),
        .IMM     (IMM),
        .OP2_SEL (OP2_SEL),
        .OPRN    (OPRN),
        .Y       (Y),
        .ZERO    (ZERO),
        .CO      (CO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b2,
                           output logic [31:0] y, output logic co);
        longint unsigned wide;
        y  = 32'h0;
        co = 1'b0;
        case (op)
            6'h01: begin
                wide = longint'(a) + longint'(b2);
                y    = wide[31:0];
                co   = wide[32];
            end
            6'h02: begin
                y  = a - b2;
                co = (a >= b2);
            end
            6'h03: begin
`ifdef ALU_MUL_EN
                wide = longint'(a) * longint'(b2);
                y    = wide[31:0];
`else
                y    = 32'h0;
`endif
            end
            6'h04: y = (b2 >= 32) ? 32'h0 : (a >> b2[4:0]);
            6'h05: y = (b2 >= 32) ? 32'h0 : (a << b2[4:0]);
            6'h06: y = a & b2;
            6'h07: y = a | b2;
            6'h08: y = ~(a | b2);
            6'h09: y = ($signed(a) < $signed(b2)) ? 32'h1 : 32'h0;
            default: y = 32'h0;
        endcase
    endtask

    // Drive at the falling edge, clock once, compare at the next falling edge.
    task automatic step(input string tag, input logic rst, input logic en,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic sel, input logic [5:0] op);
        logic [31:0] ry;
        logic        rco;
        RST = rst; EN = en; A = a; B = b; IMM = imm; OP2_SEL = sel; OPRN = op;
        if (rst) begin
            m_y  = 32'h0;
            m_co = 1'b0;
        end else if (en) begin
            ref_alu(op, a, sel ? b : imm, ry, rco);
            m_y  = ry;
            m_co = rco;
        end
        @(posedge CLK);
        @(negedge CLK);
        check({tag, ".Y"}, Y, m_y);
        check({tag, ".ZERO"}, {31'h0, ZERO}, {31'h0, (m_y == 32'h0)});
        check({tag, ".CO"}, {31'h0, CO}, {31'h0, m_co});
    endtask

    initial begin
        @(negedge CLK);
        step("reset", 1, 0, 32'h1234, 32'h5678, 32'h9, 1, 6'h01);
        check("reset_lit", {Y[30:0], ZERO, CO}, {31'h0, 1'b1, 1'b0});

        step("add_wrap", 0, 1, 32'hFFFF_FFFF, 32'h1, 32'h55, 1, 6'h01);
        check("add_wrap_lit", {31'h0, CO}, 32'h1);
        step("sub_imm", 0, 1, 32'h5, 32'h99, 32'h7, 0, 6'h02);
        check("sub_imm_lit", Y, 32'hFFFF_FFFE);
        step("slt_imm", 0, 1, 32'h5, 32'h99, 32'h7, 0, 6'h09);
        check("slt_imm_lit", Y, 32'h1);
        step("slt_ovf", 0, 1, 32'h8000_0000, 32'h1, 32'h0, 1, 6'h09);
        check("slt_ovf_lit", Y, 32'h1);
        step("slt_false", 0, 1, 32'h1, 32'h8000_0000, 32'h0, 1, 6'h09);
        step("shl_31", 0, 1, 32'h1, 32'd31, 32'h0, 1, 6'h05);
        check("shl_31_lit", Y, 32'h8000_0000);
        step("shl_32", 0, 1, 32'h1, 32'd32, 32'h0, 1, 6'h05);
        step("shr_4", 0, 1, 32'hF000_0000, 32'h0, 32'd4, 0, 6'h04);
        step("nor", 0, 1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0, 1, 6'h08);
        step("and", 0, 1, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h0, 1, 6'h06);
        step("or", 0, 1, 32'hF000_000F, 32'h0, 32'h0F00_00F0, 0, 6'h07);
        step("mul_big", 0, 1, 32'h1_0000, 32'h1_0000, 32'h0, 1, 6'h03);
        step("mul_3x4", 0, 1, 32'h3, 32'h4, 32'h0, 1, 6'h03);
        step("unknown", 0, 1, 32'hFFFF, 32'hFFFF, 32'h0, 1, 6'h3F);

        step("load12", 0, 1, 32'h5, 32'h0, 32'h7, 0, 6'h01);
        check("load12_lit", Y, 32'd12);
        for (int i = 0; i < 3; i++) begin
            step("hold", 0, 0, $urandom, $urandom, $urandom, 1'($urandom), 6'($urandom_range(1, 9)));
            check("hold_lit", Y, 32'd12);
        end
        step("rst_over_en", 1, 1, 32'h5, 32'h7, 32'h7, 1, 6'h01);
        check("rst_over_en_lit", Y, 32'h0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] rb;
            logic [31:0] ri;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            ri = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 $urandom, rb, ri, 1'($urandom), 6'($urandom_range(0, 12)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
